out_port_alloc: RTL

//  Per-output-port switch allocator with wormhole lock and credit-based flow control.

---
 rtl/out_port_alloc_if.sv | 35 +++
 rtl/out_port_alloc.sv | 139 +++++++++++++
 2 files changed

// File: rtl/out_port_alloc_if.sv
// out_port_alloc_if: allocator-side bundle of one output port.
//   req_i    per-input request (head flit routed to this output)
//   vch_i    per-input requested output VC, VCH_W bits each, packed by input
//   tail_i   per-input "head flit is a tail" flag
//   credit_i per-VC credit return strobes from downstream
//   sel_o    one-hot crossbar mux select (zero when no grant)
//   pop_o    per-input dequeue strobe
//   vch_o    VC of the locked packet
//   locked_o allocator holds a packet grant
// master: input-buffer / downstream side; slave: the allocator.
interface out_port_alloc_if #(
    parameter int PORT_N = 5,
    parameter int VCH_N  = 2
);
    localparam int VCH_W = (VCH_N > 1) ? $clog2(VCH_N) : 1;

    logic [PORT_N-1:0]       req_i;
    logic [PORT_N*VCH_W-1:0] vch_i;
    logic [PORT_N-1:0]       tail_i;
    logic [VCH_N-1:0]        credit_i;
    logic [PORT_N-1:0]       sel_o;
    logic [PORT_N-1:0]       pop_o;
    logic [VCH_W-1:0]        vch_o;
    logic                    locked_o;

    modport master (
        output req_i, vch_i, tail_i, credit_i,
        input  sel_o, pop_o, vch_o, locked_o
    );

    modport slave (
        input  req_i, vch_i, tail_i, credit_i,
        output sel_o, pop_o, vch_o, locked_o
    );
endinterface

// File: rtl/out_port_alloc.sv
// out_port_alloc: per-output-port switch allocator.
// Round-robin picks one eligible input (request present and credit available
// on its requested VC), then holds the grant (wormhole) until that input's
// tail flit pops. Per-VC downstream credit counters gate every pop.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  out_port_alloc_if.slave (requests/credits in, select/pop/vch/locked out)
// The interface instance must use the same PORT_N / VCH_N as this module.
module out_port_alloc #(
    parameter int PORT_N     = 5,
    parameter int VCH_N      = 2,
    parameter int CREDIT_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    out_port_alloc_if.slave   bus
);
    localparam int VCH_W = (VCH_N > 1) ? $clog2(VCH_N) : 1;
    localparam int CRD_W = $clog2(CREDIT_MAX + 1);
    localparam int IDX_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;
    localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CREDIT_MAX);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state;
    logic [PORT_N-1:0] sel_q;
    logic [VCH_W-1:0]  vch_q;
    logic              locked_q;
    logic [IDX_W-1:0]  rr;
    logic [IDX_W-1:0]  gnt;
    logic [CRD_W-1:0]  credit [VCH_N];

    logic [PORT_N-1:0] elig;
    logic              found;
    logic [IDX_W-1:0]  win;
    logic [IDX_W-1:0]  idx;
    logic [VCH_W-1:0]  win_vch;
    logic [PORT_N-1:0] pop;
    logic              pop_any;
    logic              tail_done;
    logic [VCH_N-1:0]  cred_dec;
    logic [VCH_N-1:0]  cred_inc;

    // Round-robin search starting at rr; first eligible input wins.
    always_comb begin
        for (int unsigned i = 0; i < PORT_N; i++) begin
            elig[i] = bus.req_i[i] && (credit[bus.vch_i[i*VCH_W +: VCH_W]] != '0);
        end
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < PORT_N; k++) begin
            idx = IDX_W'((32'(rr) + k) % PORT_N);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_vch = bus.vch_i[32'(win)*VCH_W +: VCH_W];
    end

    // sel_q is only non-zero while LOCKED, so masking with it selects input g.
    always_comb begin
        pop = '0;
        if (state == LOCKED && credit[vch_q] != '0) begin
            pop = sel_q & bus.req_i;
        end
        pop_any   = |pop;
        tail_done = |(pop & bus.tail_i);
        for (int unsigned v = 0; v < VCH_N; v++) begin
            cred_dec[v] = pop_any && (vch_q == VCH_W'(v));
            cred_inc[v] = bus.credit_i[v];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel_q    <= '0;
            vch_q    <= '0;
            locked_q <= 1'b0;
            rr       <= '0;
            gnt      <= '0;
            for (int unsigned v = 0; v < VCH_N; v++) begin
                credit[v] <= CRD_FULL;
            end
        end else begin
            for (int unsigned v = 0; v < VCH_N; v++) begin
                if (cred_inc[v] && !cred_dec[v]) begin
                    if (credit[v] != CRD_FULL) begin
                        credit[v] <= credit[v] + 1'b1;
                    end
                end else if (cred_dec[v] && !cred_inc[v]) begin
                    credit[v] <= credit[v] - 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        sel_q    <= PORT_N'(1) << win;
                        vch_q    <= win_vch;
                        locked_q <= 1'b1;
                        gnt      <= win;
                        state    <= LOCKED;
                    end else begin
                        sel_q    <= '0;
                        locked_q <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (tail_done) begin
                        sel_q    <= '0;
                        locked_q <= 1'b0;
                        rr       <= (gnt == IDX_W'(PORT_N - 1)) ? '0 : gnt + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sel_o    = sel_q;
    assign bus.pop_o    = pop;
    assign bus.vch_o    = vch_q;
    assign bus.locked_o = locked_q;

    a_sel_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(sel_q));
    a_pop_in_sel:  assert property (@(posedge clk) disable iff (rst) (pop & ~sel_q) == '0);
    a_locked_sel:  assert property (@(posedge clk) disable iff (rst) locked_q == (|sel_q));

    // A return while already full is a downstream protocol error.
    for (genvar gv = 0; gv < VCH_N; gv++) begin : g_ovf
        a_credit_ovf: assert property (@(posedge clk) disable iff (rst)
            !(cred_inc[gv] && !cred_dec[gv] && credit[gv] == CRD_FULL));
    end
endmodule
